// File: rtl/line_raster_gen.sv
// line_raster_gen: eight-octant Bresenham line rasteriser with a valid/ready
// pixel stream. One line is accepted per start pulse in IDLE; exactly one
// point is produced per Bresenham step, in order from (x0,y0) to (x1,y1).
//
// Optional feature: define LINE_CLIP_EN to suppress points outside
// XRES x YRES. Suppressed points are stepped over one per cycle without
// waiting for pix_ready. With LINE_CLIP_EN undefined every point is emitted.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; endpoints latched on start
// SETUP  | deltas, step directions, error term and remaining count computed
// DRAW   | current point presented; steps on handshake (or when clipped)
// DONE   | one-cycle done pulse, then back to IDLE
module line_raster_gen #(
  parameter int XW   = 10,
  parameter int YW   = 9,
  parameter int XRES = 640,
  parameter int YRES = 480
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  output logic          busy,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_last,
  output logic          done
);

  // Two guard bits above the wider coordinate keep dx, -dy and err signed
  // without overflow for any pair of legal endpoints.
  localparam int W = ((XW > YW) ? XW : YW) + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_DRAW,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [XW-1:0] x0_r, x1_r, x_r;
  logic [YW-1:0] y0_r, y1_r, y_r;

  logic signed [W-1:0] dx_r, dy_r, err_r, n_r;
  logic                sx_neg, sy_neg;

  logic [XW-1:0]       adx;
  logic [YW-1:0]       ady;
  logic signed [W-1:0] dx_c, dy_c;

  logic signed [W:0]   e2, dx_e, dy_e;
  logic                step_x, step_y;
  logic signed [W-1:0] err_dec, err_inc, err_nxt;

  logic                visible;
  logic                advance;
  logic                last_pt;

  // Point visibility; without clipping every point is on screen.
`ifdef LINE_CLIP_EN
  localparam logic [XW:0] XRES_L = XRES[XW:0];
  localparam logic [YW:0] YRES_L = YRES[YW:0];

  always_comb begin
    visible = ({1'b0, x_r} < XRES_L) && ({1'b0, y_r} < YRES_L);
  end
`else
  logic unused_clip_cfg;
  assign unused_clip_cfg = ^{XRES, YRES};

  always_comb begin
    visible = 1'b1;
  end
`endif

  // Absolute deltas from the latched endpoints, zero-extended to W bits.
  always_comb begin
    adx  = (x1_r >= x0_r) ? (x1_r - x0_r) : (x0_r - x1_r);
    ady  = (y1_r >= y0_r) ? (y1_r - y0_r) : (y0_r - y1_r);
    dx_c = {{(W-XW){1'b0}}, adx};
    dy_c = {{(W-YW){1'b0}}, ady};
  end

  // Bresenham step decision; both tests use the same pre-step e2.
  always_comb begin
    e2      = {err_r, 1'b0};
    dx_e    = {dx_r[W-1], dx_r};
    dy_e    = {dy_r[W-1], dy_r};
    step_x  = (e2 >= -dy_e);
    step_y  = (e2 <= dx_e);
    err_dec = step_x ? dy_r : {W{1'b0}};
    err_inc = step_y ? dx_r : {W{1'b0}};
    err_nxt = err_r - err_dec + err_inc;
  end

  // A clipped point is skipped without waiting on downstream.
  always_comb begin
    last_pt = (n_r == {W{1'b0}});
    advance = (state == S_DRAW) && (pix_ready || !visible);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        busy      = 1'b1;
        state_nxt = S_DRAW;
      end
      S_DRAW: begin
        busy      = 1'b1;
        pix_valid = visible;
        pix_last  = visible && last_pt;
        if (advance && last_pt) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Endpoint capture; only a start seen in IDLE is honoured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_r <= '0;
      x1_r <= '0;
      y0_r <= '0;
      y1_r <= '0;
    end else if ((state == S_IDLE) && start) begin
      x0_r <= x0;
      x1_r <= x1;
      y0_r <= y0;
      y1_r <= y1;
    end
  end

  // Per-line constants, fixed during SETUP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx_r   <= '0;
      dy_r   <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else if (state == S_SETUP) begin
      dx_r   <= dx_c;
      dy_r   <= dy_c;
      sx_neg <= (x1_r < x0_r);
      sy_neg <= (y1_r < y0_r);
    end
  end

  // Walking point, error term and remaining-step down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r   <= '0;
      y_r   <= '0;
      err_r <= '0;
      n_r   <= '0;
    end else if (state == S_SETUP) begin
      x_r   <= x0_r;
      y_r   <= y0_r;
      err_r <= dx_c - dy_c;
      n_r   <= (dx_c > dy_c) ? dx_c : dy_c;
    end else if (advance && !last_pt) begin
      err_r <= err_nxt;
      n_r   <= n_r - 1'b1;
      if (step_x) begin
        x_r <= sx_neg ? (x_r - 1'b1) : (x_r + 1'b1);
      end
      if (step_y) begin
        y_r <= sy_neg ? (y_r - 1'b1) : (y_r + 1'b1);
      end
    end
  end

  // The current point is shown directly; it is held while stalled.
  always_comb begin
    pix_x = x_r;
    pix_y = y_r;
  end

endmodule

// File: tb/tb_line_raster_gen.sv
// Bench for line_raster_gen (default build, clipping disabled).
module tb_line_raster_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] x0 = '0, x1 = '0;
  logic [8:0] y0 = '0, y1 = '0;
  logic       busy, pix_valid, pix_ready, pix_last, done;
  logic [9:0] pix_x;
  logic [8:0] pix_y;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int x;
    int y;
    bit last;
  } pix_t;

  typedef struct {
    int x0;
    int y0;
    int x1;
    int y1;
    int mode;   // 0: ready held high, 1: ready 1,0,0,1 plus stray start
    int exp_n;
  } vec_t;

  pix_t q[$];
  vec_t vecs[6];

  line_raster_gen #(.XW(10), .YW(9), .XRES(640), .YRES(480)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference Bresenham walk; pushes the expected pixel stream.
  function automatic void model(input int ax0, input int ay0, input int ax1, input int ay1);
    int dx, dy, sx, sy, err, n, x, y, e2;
    pix_t p;
    dx  = (ax1 >= ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = (ay1 >= ay0) ? ay1 - ay0 : ay0 - ay1;
    sx  = (ax1 >= ax0) ? 1 : -1;
    sy  = (ay1 >= ay0) ? 1 : -1;
    err = dx - dy;
    n   = (dx > dy) ? dx : dy;
    x   = ax0;
    y   = ay0;
    for (int i = 0; i <= n; i++) begin
      p.x = x; p.y = y; p.last = (i == n);
      q.push_back(p);
      e2 = 2 * err;
      if (e2 >= -dy) begin err -= dy; x += sx; end
      if (e2 <= dx)  begin err += dx; y += sy; end
    end
  endfunction

  function automatic bit ready_at(input int mode, input int c);
    if (mode == 0) return 1'b1;
    return (c % 4 == 0) || (c % 4 == 3);
  endfunction

  task automatic run_line(input vec_t v, input string name);
    int   cyc, hs, first_v, done_cyc, lasts, lx, ly;
    pix_t e;
    hs = 0; first_v = -1; done_cyc = -1; lasts = 0; lx = -1; ly = -1;
    q.delete();
    model(v.x0, v.y0, v.x1, v.y1);
    @(posedge clk); #1;
    x0 = 10'(v.x0); y0 = 9'(v.y0); x1 = 10'(v.x1); y1 = 9'(v.y1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pix_ready = ready_at(v.mode, 0);
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      if (cyc == 0) chk(busy && !pix_valid, {name, " setup busy"}, {busy, pix_valid}, 2);
      if (pix_valid) begin
        if (first_v < 0) first_v = cyc;
        if (q.size() == 0) begin
          chk(1'b0, {name, " extra pixel"}, int'(pix_x), -1);
        end else begin
          e = q[0];
          total++;
          if (int'(pix_x) == e.x && int'(pix_y) == e.y && pix_last == e.last) passed++;
          else $display("FAIL %s pixel: got (%0d,%0d,last=%0d) expected (%0d,%0d,last=%0d)",
                        name, pix_x, pix_y, pix_last, e.x, e.y, e.last);
          if (pix_ready) begin
            void'(q.pop_front());
            hs++;
            lx = int'(pix_x); ly = int'(pix_y);
            if (pix_last) lasts++;
          end
        end
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      pix_ready = ready_at(v.mode, cyc);
      if (v.mode == 1 && cyc == 5) begin
        x0 = 10'd100; y0 = 9'd100; x1 = 10'd200; y1 = 9'd50;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk(done_cyc >= 0, {name, " done seen"}, done_cyc, v.exp_n + 1);
    chk(hs == v.exp_n, {name, " pixel count"}, hs, v.exp_n);
    chk(q.size() == 0, {name, " scoreboard empty"}, q.size(), 0);
    chk(lasts == 1, {name, " pix_last count"}, lasts, 1);
    chk(lx == v.x1 && ly == v.y1, {name, " end x"}, lx, v.x1);
    chk(first_v == 1, {name, " first valid cycle"}, first_v, 1);
    if (v.mode == 0) chk(done_cyc == v.exp_n + 1, {name, " done cycle"}, done_cyc, v.exp_n + 1);
    @(negedge clk);
    chk(!busy && !done && !pix_valid, {name, " idle after done"}, {busy, done, pix_valid}, 0);
  endtask

  initial begin
    bit found;
    vecs[0] = '{10, 20, 30, 40, 0, 21};
    vecs[1] = '{5, 10, 3, 2, 0, 9};
    vecs[2] = '{7, 7, 7, 7, 0, 1};
    vecs[3] = '{12, 0, 0, 5, 0, 13};
    vecs[4] = '{12, 0, 0, 5, 1, 13};
    vecs[5] = '{0, 0, 0, 6, 1, 7};

    pix_ready = 1'b1;
    #12;
    chk(!busy && !pix_valid && !pix_last && !done && pix_x == 0 && pix_y == 0,
        "reset outputs", {busy, pix_valid, pix_last, done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_line(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of (0,0)->(20,0), on its 4th pixel.
    @(posedge clk); #1;
    x0 = 10'd0; y0 = 9'd0; x1 = 10'd20; y1 = 9'd0;
    pix_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pix_valid && int'(pix_x) == 3) begin
        found = 1'b1;
        break;
      end
    end
    chk(found, "reached 4th pixel", int'(found), 1);
    #2 rst = 1'b1;
    #1;
    chk(!busy && !pix_valid && !pix_last && !done && pix_x == 0 && pix_y == 0,
        "async reset outputs", {busy, pix_valid, pix_last, done, int'(pix_x)}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk(!busy && !pix_valid, "idle after reset", {busy, pix_valid}, 0);
    run_line('{1, 1, 3, 1, 0, 3}, "post-reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
